// File: rtl/ss_arbiter.sv
// ss_arbiter: round-robin owner of the seven-segment display with minimum hold and a one-cycle blank on handover.
// Optional SS_ARB_LOCK_EN: PB[0] press toggles an ownership lock that suppresses preemption.
module ss_arbiter #(
    parameter int NREQ        = 4,
    parameter int SEGMENT_W   = 8,
    parameter int DISPLAY_W   = 6,
    parameter int PB_W        = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                                          CLK,
    input  logic                                          nRST,
    input  logic [NREQ-1:0]                               req,
    input  logic [NREQ-1:0][DISPLAY_W-1:0][SEGMENT_W-1:0] data,
    input  logic [PB_W-1:0]                               PB,
    output logic [NREQ-1:0]                               grant,
    output logic [$clog2(NREQ)-1:0]                       owner,
    output logic                                          locked,
    output logic [DISPLAY_W-1:0][SEGMENT_W-1:0]           SS
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;
    state_t state, state_n;
    logic [OW-1:0] last, sel;
    logic [CW-1:0] cnt;
    logic drop, preempt, leave, take, lock_q, unused_pb;
    logic [NREQ-1:0] grant_n;
    logic [DISPLAY_W-1:0][SEGMENT_W-1:0] ss_n;
    int j;

    // Scan downward so the requester nearest after last is written last and wins.
    always_comb begin
        sel = '0;
        j = 0;
        for (int i = NREQ; i >= 1; i--) begin
            j = (int'(last) + i) % NREQ;
            if (req[j[OW-1:0]]) sel = j[OW-1:0];
        end
    end

    assign drop    = (state == OWN) && !req[owner];
    assign preempt = (state == OWN) && (cnt == CW'(HOLD_CYCLES)) && |(req & ~grant) && !lock_q;
    assign leave   = drop || preempt;
    assign take    = (state != OWN) && |req;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = (state == OWN) ? (leave ? BLANK : OWN) : (|req ? OWN : IDLE);
    end

    always_comb begin
        grant_n = take ? (NREQ'(1) << sel) : (leave ? '0 : grant);
        ss_n    = (state == OWN && !leave) ? data[owner] : '1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            grant <= '0;
            owner <= '0;
            last  <= OW'(NREQ - 1);
            cnt   <= '0;
            SS    <= '1;
        end else begin
            grant <= grant_n;
            SS    <= ss_n;
            if (take) begin
                owner <= sel;
                cnt   <= '0;
            end else if (leave) begin
                owner <= '0;
                last  <= owner;
            end else if (state == OWN && cnt != CW'(HOLD_CYCLES)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign unused_pb = ^PB;

`ifdef SS_ARB_LOCK_EN
    // pb_q[1:0] synchronise PB[0]; pb_q[2] holds the previous synchronised value for edge detect.
    logic [2:0] pb_q;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pb_q   <= '1;
            lock_q <= 1'b0;
        end else begin
            pb_q   <= {pb_q[1:0], PB[0]};
            lock_q <= leave ? 1'b0 : ((state == OWN && pb_q[2] && !pb_q[1]) ? ~lock_q : lock_q);
        end
    end
`else
    assign lock_q = 1'b0;
`endif

    assign locked = lock_q;
endmodule

// File: tb/tb_ss_arbiter.sv
// tb_ss_arbiter: directed checks of ss_arbiter with HOLD_CYCLES=4, NREQ=4.
module tb_ss_arbiter;
    localparam logic [47:0] BLANK_SS = {48{1'b1}};
    logic CLK = 1'b0;
    logic nRST;
    logic [3:0] req;
    logic [3:0][5:0][7:0] data;
    logic [3:0] PB;
    logic [3:0] grant;
    logic [1:0] owner;
    logic locked;
    logic [5:0][7:0] SS;
    int checks = 0;
    int failures = 0;

    ss_arbiter #(.NREQ(4), .SEGMENT_W(8), .DISPLAY_W(6), .PB_W(4), .HOLD_CYCLES(4)) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .data(data), .PB(PB),
        .grant(grant), .owner(owner), .locked(locked), .SS(SS)
    );

    always #5 CLK = ~CLK;

    function automatic logic [47:0] pat(input int i);
        logic [47:0] p;
        for (int d = 0; d < 6; d++) p[d*8 +: 8] = 8'(i * 16 + d + 1);
        return p;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        req = '0;
        PB = '1;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        req = '0;
        PB = '1;
        nRST = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (grant !== 4'b0000) begin failures++; $display("FAIL reset grant pass %0d: got %b want 0000", k, grant); end
            checks++;
            if (SS !== BLANK_SS) begin failures++; $display("FAIL reset SS pass %0d: got %h want %h", k, SS, BLANK_SS); end
            checks++;
            if (owner !== 2'd0) begin failures++; $display("FAIL reset owner pass %0d: got %0d want 0", k, owner); end
            checks++;
            if (locked !== 1'b0) begin failures++; $display("FAIL reset locked pass %0d: got %b want 0", k, locked); end
            nRST = 1'b1;
            step();
            step();
        end
    endtask

    task automatic test_preempt();
        logic [3:0] eg [8];
        logic [47:0] es [8];
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100};
        es = '{BLANK_SS, pat(0), pat(0), pat(0), pat(0), BLANK_SS, BLANK_SS, pat(2)};
        apply_reset();
        req = 4'b0101;
        for (int e = 0; e < 8; e++) begin
            step();
            checks++;
            if (grant !== eg[e]) begin failures++; $display("FAIL preempt grant edge %0d: got %b want %b", e + 1, grant, eg[e]); end
            checks++;
            if (SS !== es[e]) begin failures++; $display("FAIL preempt SS edge %0d: got %h want %h", e + 1, SS, es[e]); end
        end
        checks++;
        if (owner !== 2'd2) begin failures++; $display("FAIL preempt owner: got %0d want 2", owner); end
    endtask

    task automatic test_drop();
        apply_reset();
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || owner !== 2'd2) begin failures++; $display("FAIL drop grant: got %b/%0d want 0100/2", grant, owner); end
        step();
        checks++;
        if (SS !== pat(2)) begin failures++; $display("FAIL drop SS owned: got %h want %h", SS, pat(2)); end
        req = 4'b0000;
        for (int e = 0; e < 3; e++) begin
            step();
            checks++;
            if (grant !== 4'b0000) begin failures++; $display("FAIL drop grant after %0d: got %b want 0000", e, grant); end
            checks++;
            if (SS !== BLANK_SS) begin failures++; $display("FAIL drop SS after %0d: got %h want %h", e, SS, BLANK_SS); end
        end
        checks++;
        if (owner !== 2'd0) begin failures++; $display("FAIL drop owner idle: got %0d want 0", owner); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        apply_reset();
        req = 4'b1111;
        for (int n = 1; n <= 30; n++) begin
            step();
            exp_g = ((n - 1) % 6 < 5) ? 4'(1 << (((n - 1) / 6) % 4)) : 4'b0000;
            checks++;
            if (grant !== exp_g) begin failures++; $display("FAIL rr grant edge %0d: got %b want %b", n, grant, exp_g); end
            if ((n - 1) % 6 < 5) begin
                checks++;
                if (owner !== 2'(((n - 1) / 6) % 4)) begin failures++; $display("FAIL rr owner edge %0d: got %0d want %0d", n, owner, ((n - 1) / 6) % 4); end
            end
        end
    endtask

`ifdef SS_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        req = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010) begin failures++; $display("FAIL lock initial grant: got %b want 0010", grant); end
        req = 4'b1010;
        PB[0] = 1'b0;
        step();
        step();
        checks++;
        if (locked !== 1'b0) begin failures++; $display("FAIL lock early: got %b want 0", locked); end
        step();
        checks++;
        if (locked !== 1'b1) begin failures++; $display("FAIL lock set: got %b want 1", locked); end
        PB[0] = 1'b1;
        for (int e = 0; e < 20; e++) begin
            step();
            checks++;
            if (grant !== 4'b0010 || locked !== 1'b1) begin failures++; $display("FAIL lock hold %0d: got %b/%b want 0010/1", e, grant, locked); end
        end
        req = 4'b1000;
        step();
        checks++;
        if (grant !== 4'b0000 || locked !== 1'b0) begin failures++; $display("FAIL lock release: got %b/%b want 0000/0", grant, locked); end
        step();
        checks++;
        if (grant !== 4'b1000) begin failures++; $display("FAIL lock handover: got %b want 1000", grant); end
    endtask
`else
    task automatic test_lock();
        apply_reset();
        req = 4'b0010;
        step();
        req = 4'b1010;
        PB[0] = 1'b0;
        for (int e = 2; e <= 5; e++) begin
            step();
            checks++;
            if (grant !== 4'b0010 || locked !== 1'b0) begin failures++; $display("FAIL nolock hold edge %0d: got %b/%b want 0010/0", e, grant, locked); end
        end
        step();
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL nolock preempt: got %b want 0000", grant); end
        step();
        checks++;
        if (grant !== 4'b1000) begin failures++; $display("FAIL nolock handover: got %b want 1000", grant); end
        PB[0] = 1'b1;
    endtask
`endif

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0100;
        step();
        step();
        checks++;
        if (SS !== pat(2)) begin failures++; $display("FAIL async SS owned: got %h want %h", SS, pat(2)); end
        data[2] = 48'h123456789ABC;
        data[0] = 48'h0;
        step();
        checks++;
        if (SS !== 48'h123456789ABC) begin failures++; $display("FAIL data update: got %h want 123456789abc", SS); end
        data[2] = pat(2);
        data[0] = pat(0);
        #3;
        nRST = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || owner !== 2'd0) begin failures++; $display("FAIL async grant: got %b/%0d want 0000/0", grant, owner); end
        checks++;
        if (SS !== BLANK_SS) begin failures++; $display("FAIL async SS: got %h want %h", SS, BLANK_SS); end
        req = 4'b1111;
        #2;
        nRST = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0001 || owner !== 2'd0) begin failures++; $display("FAIL async regrant: got %b/%0d want 0001/0", grant, owner); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) data[i] = pat(i);
        test_reset();
        test_preempt();
        test_drop();
        test_round_robin();
        test_lock();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
